cpu_control_unit: RTL

Multi-cycle instruction sequencer for the CISC core. It replaces the separate program counter, instruction register and decoder/enable logic with one parametrised unit. It adds:
- wait-state handshaking to data memory,
- conditional jumps,
- a hardware call/return stack of configurable depth,
- a halt state.

It drives the ROM address, and it drives the decoded fields consumed by the data path and ALU.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/call_stack.sv | 45 ++++
 rtl/cpu_control_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle CISC control unit.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEMRD  = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_STORE = 4'hC;
  localparam logic [3:0] OP_JMP   = 4'hD;
  localparam logic [3:0] OP_CALL  = 4'hE;
  localparam logic [3:0] OP_SYS   = 4'hF;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_NZ     = 2'b10;
  localparam logic [1:0] COND_N      = 2'b11;

  localparam logic [1:0] SYS_RET  = 2'b00;
  localparam logic [1:0] SYS_HALT = 2'b01;

  localparam logic [1:0] AM_IMM     = 2'b00;
  localparam logic [1:0] AM_REG     = 2'b01;
  localparam logic [1:0] AM_RAM     = 2'b10;
  localparam logic [1:0] AM_RAM_IND = 2'b11;

  // Modes other than immediate/register reach into data memory.
  function automatic logic is_ram_mode(input logic [1:0] mode);
    return !(mode == AM_IMM || mode == AM_REG);
  endfunction

endpackage

// File: rtl/call_stack.sv
// Parametrised LIFO holding return addresses; push/pop ignored when full/empty.
module call_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    top_idx;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_idx  = IW'(count);
  assign top_idx = IW'(count - CW'(1));
  assign dout    = mem[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; count==0 already marks every entry invalid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer: PC, IR, decode, memory handshake, jumps, call stack, halt.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int ROM_ADDR_WIDTH  = 8,
  parameter int ROM_WIDTH       = 16,
  parameter int OP_WIDTH        = 4,
  parameter int ADDR_MODE_WIDTH = 2,
  parameter int OPERAND_WIDTH   = 8,
  parameter int STACK_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ROM_ADDR_WIDTH-1:0]  rom_addr,
  input  logic [ROM_WIDTH-1:0]       rom_data,
  input  logic                       zero_flag,
  input  logic                       sign_flag,
  output logic [OP_WIDTH-1:0]        alu_op_out,
  output logic [ADDR_MODE_WIDTH-1:0] addr_mode_out,
  output logic [OPERAND_WIDTH-1:0]   operand_out,
  output logic                       mem_req,
  output logic                       mem_we,
  input  logic                       mem_ack,
  output logic                       execute_ena,
  output logic                       write_reg_ena,
  output logic                       halted,
  output logic                       stack_err,
  output logic [2:0]                 state_out
);

  localparam int COND_LSB = OPERAND_WIDTH;
  localparam int MODE_LSB = OPERAND_WIDTH + 2;
  localparam int OP_LSB   = MODE_LSB + ADDR_MODE_WIDTH;

  state_t                    state, next_state;
  logic [ROM_ADDR_WIDTH-1:0] pc, pc_next, pc_plus1, target;
  logic [ROM_WIDTH-1:0]      ir;
  logic [OP_WIDTH-1:0]       opcode;
  logic [1:0]                cond;
  logic                      is_alu, is_ram, jmp_taken, set_err;
  logic                      push, pop, stk_full, stk_empty;
  logic [ROM_ADDR_WIDTH-1:0] stk_dout;

  assign opcode   = ir[OP_LSB +: OP_WIDTH];
  assign cond     = ir[COND_LSB +: 2];
  assign target   = ir[ROM_ADDR_WIDTH-1:0];
  assign pc_plus1 = pc + ROM_ADDR_WIDTH'(1);
  assign is_alu   = (opcode < OP_WIDTH'(OP_STORE));
  assign is_ram   = is_ram_mode(2'(ir[MODE_LSB +: ADDR_MODE_WIDTH]));

  assign rom_addr      = pc;
  assign alu_op_out    = opcode;
  assign addr_mode_out = ir[MODE_LSB +: ADDR_MODE_WIDTH];
  assign operand_out   = ir[OPERAND_WIDTH-1:0];
  assign halted        = (state == HALT);
  assign state_out     = state;

  always_comb begin
    unique case (cond)
      COND_ALWAYS: jmp_taken = 1'b1;
      COND_Z:      jmp_taken = zero_flag;
      COND_NZ:     jmp_taken = !zero_flag;
      COND_N:      jmp_taken = sign_flag;
      default:     jmp_taken = 1'b0;
    endcase
  end

  call_stack #(.WIDTH(ROM_ADDR_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus1),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_state    = state;
    pc_next       = pc;
    push          = 1'b0;
    pop           = 1'b0;
    set_err       = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    execute_ena   = 1'b0;
    write_reg_ena = 1'b0;
    unique case (state)
      FETCH:  next_state = DECODE;
      DECODE: next_state = (is_alu && is_ram) ? MEMRD : EXEC;
      MEMRD: begin
        mem_req = 1'b1;
        if (mem_ack) next_state = EXEC;
      end
      EXEC: begin
        next_state = FETCH;
        pc_next    = pc_plus1;
        if (is_alu) begin
          execute_ena = 1'b1;
        end else if (opcode == OP_WIDTH'(OP_STORE)) begin
          next_state = WRITE;
          pc_next    = pc;
        end else if (opcode == OP_WIDTH'(OP_JMP)) begin
          if (jmp_taken) pc_next = target;
        end else if (opcode == OP_WIDTH'(OP_CALL)) begin
          if (stk_full) begin
            set_err    = 1'b1;
            next_state = HALT;
            pc_next    = pc;
          end else begin
            push    = 1'b1;
            pc_next = target;
          end
        end else if (cond == SYS_RET) begin
          if (stk_empty) begin
            set_err    = 1'b1;
            next_state = HALT;
            pc_next    = pc;
          end else begin
            pop     = 1'b1;
            pc_next = stk_dout;
          end
        end else if (cond == SYS_HALT) begin
          next_state = HALT;
          pc_next    = pc;
        end
      end
      WRITE: begin
        if (is_ram) begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          if (mem_ack) begin
            next_state = FETCH;
            pc_next    = pc_plus1;
          end
        end else begin
          write_reg_ena = 1'b1;
          next_state    = FETCH;
          pc_next       = pc_plus1;
        end
      end
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH;
      pc        <= '0;
      ir        <= '0;
      stack_err <= 1'b0;
    end else begin
      state <= next_state;
      pc    <= pc_next;
      if (state == FETCH) ir <= rom_data;
      if (set_err) stack_err <= 1'b1;
    end
  end

endmodule
